// File: rtl/common.sv
// Shared types and constants for the UART transmit path.
package common;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with head data visible combinationally; pushes when full
// and pops when empty are ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered bytes serialised LSB first on io_tx,
// frames sent back-to-back while the FIFO has data.
module uart_tx
    import common::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [UART_DATA_BITS-1:0]     tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          io_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

    uart_tx_state_t            state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      io_tx_q, io_tx_d;
    logic                      busy_q;

    logic                      push, pop, bit_end;
    logic                      fifo_full, fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_rdata;

    assign tx_ready = !fifo_full;
    assign push     = tx_valid && tx_ready;
    assign bit_end  = (cnt_q == CNT_LAST);
    assign io_tx    = io_tx_q;
    assign tx_busy  = busy_q;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i (tx_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit so frames abut.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is derived from next state so io_tx can be a flop.
        unique case (state_d)
            START:   io_tx_d = 1'b0;
            DATA:    io_tx_d = shift_d[0];
            default: io_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            io_tx_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            io_tx_q <= io_tx_d;
            // IDLE with data pops immediately, so "not IDLE" covers both
            // a frame in flight and a queued byte.
            busy_q  <= (state_d != IDLE);
        end
    end

endmodule
